st_symbol_packer_ctrl: RTL

Controller that sequences the single-write/single-read lookahead data RAM as a circular symbol buffer for the Avalon-ST data format adapter. Accepts 8-bit symbols with SOP/EOP on the sink side and writes them into the RAM. Fetches each group of up to 4 symbols back through the RAM read port and emits 32-bit beats with sop/eop/empty on the source side. The RAM is a sibling instance; this block owns all of its address, write and read sequencing.

---
 rtl/st_packer_pkg.sv | 28 ++
 rtl/st_symbol_packer_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/st_packer_pkg.sv
// Shared constants, FSM encoding and lane helpers for the Avalon-ST symbol packer controller.
package st_packer_pkg;

  localparam int SYMBOLS_PER_BEAT = 4;
  localparam int SYMBOL_W         = 8;
  localparam int BEAT_W           = SYMBOLS_PER_BEAT * SYMBOL_W;
  localparam int EMPTY_W          = 2;
  localparam int LANE_W           = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DRAIN   = 2'd2,
    PRESENT = 2'd3
  } pk_state_e;

  // Unused symbol lanes of a beat holding n symbols; only meaningful on an eop beat.
  function automatic logic [EMPTY_W-1:0] empty_lanes(input logic [2:0] n, input logic eop);
    logic [EMPTY_W-1:0] res;
    if (eop) begin
      res = EMPTY_W'(3'd4 - n);
    end else begin
      res = {EMPTY_W{1'b0}};
    end
    return res;
  endfunction

endpackage

// File: rtl/st_symbol_packer_ctrl.sv
// Circular symbol buffer sequencer: packs 8-bit sink symbols into 32-bit source beats via an external RAM.
// Optional statistics counters are built when PACKER_STATS_EN is defined.
module st_symbol_packer_ctrl
  import st_packer_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SYMBOL_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sop,
  input  logic                in_eop,
  output logic [BEAT_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sop,
  output logic                out_eop,
  output logic [EMPTY_W-1:0]  out_empty,
  output logic [ADDR_W-1:0]   ram_wr_address,
  output logic [SYMBOL_W-1:0] ram_wr_writedata,
  output logic                ram_wr_write,
  input  logic                ram_wr_waitrequest,
  output logic [ADDR_W-1:0]   ram_rd_address,
  input  logic [SYMBOL_W-1:0] ram_rd_readdata
`ifdef PACKER_STATS_EN
  ,
  output logic [15:0]         stat_pkts,
  output logic [15:0]         stat_stall
`endif
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic                accept_s, close_s, release_s, issue_s, last_issue_s, drain_busy_s;
  logic [ADDR_W-1:0]   wr_ptr_r, rd_ptr_r, rd_slot_s;
  logic [ADDR_W:0]     count_r, grp_cnt_r;
  logic [LANE_W-1:0]   sym_in_grp_r, lane_r;
  logic [DEPTH-1:0]    sop_flag_r, eop_flag_r;
  logic [2:0]          n_r;
  logic                grp_sop_r, grp_eop_r;
  logic [RD_LATENCY-1:0] cap_vld_r;
  logic [LANE_W-1:0]   cap_lane_r [RD_LATENCY];
  pk_state_e           state_r, next_state_s;
  logic [BEAT_W-1:0]   out_data_r;
  logic                out_valid_r, out_sop_r, out_eop_r;
  logic [EMPTY_W-1:0]  out_empty_r;

  assign in_ready         = !ram_wr_waitrequest && (count_r < DEPTH_C);
  assign accept_s         = in_valid && in_ready;
  assign close_s          = accept_s && (in_eop || (sym_in_grp_r == 2'd3));
  assign release_s        = (state_r == PRESENT) && out_valid_r && out_ready;
  assign rd_slot_s        = rd_ptr_r + ADDR_W'(lane_r);
  assign issue_s          = (state_r == FETCH);
  assign last_issue_s     = issue_s && ((lane_r == 2'd3) || eop_flag_r[rd_slot_s]);

  assign ram_wr_write     = accept_s;
  assign ram_wr_address   = wr_ptr_r;
  assign ram_wr_writedata = in_data;
  assign ram_rd_address   = rd_slot_s;

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_sop   = out_sop_r;
  assign out_eop   = out_eop_r;
  assign out_empty = out_empty_r;

  // Reads still in flight ahead of the final pipeline stage keep DRAIN waiting.
  always_comb begin
    drain_busy_s = 1'b0;
    for (int k = 0; k < RD_LATENCY - 1; k++) begin
      drain_busy_s = drain_busy_s | cap_vld_r[k];
    end
  end

  // Next-state logic of the fetch/present sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (grp_cnt_r != '0) next_state_s = FETCH;   else next_state_s = IDLE;
      FETCH:   if (last_issue_s)    next_state_s = DRAIN;   else next_state_s = FETCH;
      DRAIN:   if (!drain_busy_s)   next_state_s = PRESENT; else next_state_s = DRAIN;
      PRESENT: if (release_s)       next_state_s = IDLE;    else next_state_s = PRESENT;
      default: next_state_s = IDLE;
    endcase
  end

  // Write side: slot allocation, per-slot framing flags, occupancy and closed-group count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r     <= {ADDR_W{1'b0}};
      count_r      <= {(ADDR_W+1){1'b0}};
      grp_cnt_r    <= {(ADDR_W+1){1'b0}};
      sym_in_grp_r <= 2'd0;
      sop_flag_r   <= {DEPTH{1'b0}};
      eop_flag_r   <= {DEPTH{1'b0}};
    end else begin
      if (accept_s) begin
        wr_ptr_r             <= wr_ptr_r + ADDR_W'(1'b1);
        sym_in_grp_r         <= close_s ? 2'd0 : sym_in_grp_r + 2'd1;
        sop_flag_r[wr_ptr_r] <= in_sop && (sym_in_grp_r == 2'd0);
        eop_flag_r[wr_ptr_r] <= in_eop;
      end
      count_r <= count_r + (ADDR_W+1)'(accept_s)
                 - (release_s ? (ADDR_W+1)'(n_r) : {(ADDR_W+1){1'b0}});
      case ({close_s, release_s})
        2'b10:   grp_cnt_r <= grp_cnt_r + (ADDR_W+1)'(1'b1);
        2'b01:   grp_cnt_r <= grp_cnt_r - (ADDR_W+1)'(1'b1);
        default: grp_cnt_r <= grp_cnt_r;
      endcase
    end
  end

  // Read side: state register, lane issue, capture pipeline and registered beat outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      rd_ptr_r    <= {ADDR_W{1'b0}};
      lane_r      <= 2'd0;
      n_r         <= 3'd0;
      grp_sop_r   <= 1'b0;
      grp_eop_r   <= 1'b0;
      cap_vld_r   <= {RD_LATENCY{1'b0}};
      for (int k = 0; k < RD_LATENCY; k++) cap_lane_r[k] <= 2'd0;
      out_data_r  <= {BEAT_W{1'b0}};
      out_valid_r <= 1'b0;
      out_sop_r   <= 1'b0;
      out_eop_r   <= 1'b0;
      out_empty_r <= {EMPTY_W{1'b0}};
    end else begin
      state_r       <= next_state_s;
      cap_vld_r[0]  <= issue_s;
      cap_lane_r[0] <= lane_r;
      for (int k = 1; k < RD_LATENCY; k++) begin
        cap_vld_r[k]  <= cap_vld_r[k-1];
        cap_lane_r[k] <= cap_lane_r[k-1];
      end

      if (state_r == IDLE) begin
        lane_r     <= 2'd0;
        out_data_r <= {BEAT_W{1'b0}};
      end else if (cap_vld_r[RD_LATENCY-1]) begin
        case (cap_lane_r[RD_LATENCY-1])
          2'd0:    out_data_r[31:24] <= ram_rd_readdata;
          2'd1:    out_data_r[23:16] <= ram_rd_readdata;
          2'd2:    out_data_r[15:8]  <= ram_rd_readdata;
          default: out_data_r[7:0]   <= ram_rd_readdata;
        endcase
      end

      if (issue_s) begin
        lane_r <= lane_r + 2'd1;
        if (lane_r == 2'd0) grp_sop_r <= sop_flag_r[rd_slot_s];
        if (last_issue_s) begin
          n_r       <= {1'b0, lane_r} + 3'd1;
          grp_eop_r <= eop_flag_r[rd_slot_s];
        end
      end

      if ((state_r == DRAIN) && (next_state_s == PRESENT)) begin
        out_valid_r <= 1'b1;
        out_sop_r   <= grp_sop_r;
        out_eop_r   <= grp_eop_r;
        out_empty_r <= empty_lanes(n_r, grp_eop_r);
      end else if (release_s) begin
        out_valid_r <= 1'b0;
        rd_ptr_r    <= rd_ptr_r + ADDR_W'(n_r);
      end
    end
  end

`ifdef PACKER_STATS_EN
  logic [15:0] stat_pkts_r, stat_stall_r;

  assign stat_pkts  = stat_pkts_r;
  assign stat_stall = stat_stall_r;

  // Saturating counters of delivered packets and backpressured cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_pkts_r  <= 16'h0000;
      stat_stall_r <= 16'h0000;
    end else begin
      if (release_s && out_eop_r && (stat_pkts_r != 16'hFFFF)) stat_pkts_r <= stat_pkts_r + 16'h0001;
      if (out_valid_r && !out_ready && (stat_stall_r != 16'hFFFF)) stat_stall_r <= stat_stall_r + 16'h0001;
    end
  end
`endif

endmodule
